// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit that sits in EX beside the ALU. It runs
//   MULT/MULTU (shift-add) and DIV/DIVU (restoring), one iteration per cycle,
//   into the architectural HI/LO registers. It also serves MFHI/MFLO as an
//   EX result and MTHI/MTLO writes. While an operation is in flight, stall
//   holds PC, IF/ID and ID/EX.
//
//   State table
//     IDLE | no operation in flight
//     BUSY | iterating; count_q holds the number of iterations completed
//     DONE | HI/LO were just written; done pulses; a new op may start
//
// Ports
//   clock      pipeline clock, all state updates on posedge
//   reset_n    synchronous active-low reset
//   op_valid   ID/EX holds a valid instruction for this unit
//   op         0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO
//   A, B       rs / rt operand values
//   flush      abort the in-flight operation
//   stall      hold upstream stages this cycle
//   done       one-cycle pulse after HI/LO are updated by a mul/div
//   mf_result  HI (MFHI) or LO (MFLO) when op_valid, else 0
//   hi, lo     current HI/LO registers
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] mf_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // acc: product high half / partial remainder; shf: product low half / quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw_q, a_raw_d;   // unmodified A, needed for divide-by-zero
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;       // negate product / quotient
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;

  logic             is_md, is_signed, start, last_iter;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] acc_it, shf_it, quo, rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_md     = op_valid && (op == OP_MULT || op == OP_MULTU ||
                             op == OP_DIV  || op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    start     = is_md && !flush && (state_q != ST_BUSY);
    last_iter = (count_q == CNT_W'(WIDTH - 1));

    a_neg = is_signed && A[WIDTH-1];
    b_neg = is_signed && B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;

    // One shift-add step: add multiplicand if multiplier LSB set, then shift
    // the {carry, acc, shf} pair right so the multiplier bits drain out.
    mul_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opnd_q} : '0);

    // One restoring step: bring in the next dividend bit, try to subtract.
    div_shift = {acc_q, shf_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    acc_it = '0;
    shf_it = '0;
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_it = div_diff[WIDTH-1:0];
        shf_it = {shf_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_it = div_shift[WIDTH-1:0];
        shf_it = {shf_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_it = mul_sum[WIDTH:1];
      shf_it = {mul_sum[0], shf_q[WIDTH-1:1]};
    end

    prod = {acc_it, shf_it};
    if (neg_q) prod = -prod;
    quo = neg_q ? -shf_it : shf_it;
    rem = rem_neg_q ? -acc_it : acc_it;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    shf_d     = shf_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;

    if (state_q == ST_BUSY) begin
      if (flush) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        acc_d   = acc_it;
        shf_d   = shf_it;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          state_d = ST_DONE;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (div0_q) begin
            // Signed or not, divide-by-zero reports all-ones and the raw dividend.
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
    end else begin
      state_d = ST_IDLE;
      if (op_valid && op == OP_MTHI) hi_d = A;
      if (op_valid && op == OP_MTLO) lo_d = A;
      if (start) begin
        state_d   = ST_BUSY;
        count_d   = '0;
        acc_d     = '0;
        shf_d     = a_mag;
        opnd_d    = b_mag;
        a_raw_d   = A;
        is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
        neg_d     = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        div0_d    = (B == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      shf_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      shf_q     <= shf_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  always_comb begin
    // BUSY stalls everything, including MF*/MT* waiting on the result.
    stall = reset_n && !flush &&
            ((state_q == ST_BUSY) || (state_q == ST_IDLE && is_md));
    done  = (state_q == ST_DONE);
    hi    = hi_q;
    lo    = lo_q;
    mf_result = '0;
    if (op_valid && op == OP_MFHI) mf_result = hi_q;
    if (op_valid && op == OP_MFLO) mf_result = lo_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed vectors for mul/div,
// MF*/MT* interaction, back-to-back issue, flush and reset aborts.
module tb_ex_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] mf_result, hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .A(A), .B(B), .flush(flush), .stall(stall), .done(done),
    .mf_result(mf_result), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge. Issues a mul/div, then holds mop on the
  // bus while busy and returns in the first cycle with done high (or after
  // a cycle budget).
  task automatic run_md(input string tag, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_st, input logic [3:0] mop,
                        output int busy, output int stl, output logic [31:0] mf_first);
    op_valid = 1'b1; op = o; A = a; B = b;
    #1 chk({tag, "_start_stall"}, 32'(stall), 32'(exp_st));
    @(negedge clock);
    op_valid = (mop != 4'd0); op = mop; A = 32'h1234_5678; B = 32'd0;
    #1 mf_first = mf_result;
    busy = 0; stl = 0;
    while (!done && busy < 100) begin
      if (stall) stl++;
      busy++;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic check_res(input string tag, input int busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    chk({tag, "_latency"}, 32'(busy), 32'd32);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic go_idle(input string tag);
    op_valid = 1'b0; op = 4'd0;
    @(negedge clock);
    #1 chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    int busy, stl, n;
    logic [31:0] mf0;

    // Reset with a MULT presented: nothing must start, stall held low.
    reset_n = 1'b0; op_valid = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4;
    @(negedge clock);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1; op = 4'd5;
    #1 chk("rst_mfhi", mf_result, 32'd0);
    op = 4'd6;
    #1 chk("rst_mflo", mf_result, 32'd0);
    op_valid = 1'b0; op = 4'd0;
    @(negedge clock);
    #1 chk("rst_idle_done", 32'(done), 32'd0);

    run_md("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd0, busy, stl, mf0);
    check_res("multu_max", busy, 32'hFFFF_FFFE, 32'h0000_0001);
    chk("multu_max_stall_cycles", 32'(stl), 32'd32);
    chk("multu_max_done_stall", 32'(stall), 32'd0);
    go_idle("multu_max");

    run_md("mult_neg", 4'd1, 32'hFFFF_FFF9, 32'd3, 1'b1, 4'd0, busy, stl, mf0);
    check_res("mult_neg", busy, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // Back-to-back from DONE: no stall in the DONE cycle.
    run_md("divu_b2b", 4'd4, 32'd20, 32'd3, 1'b0, 4'd0, busy, stl, mf0);
    check_res("divu_b2b", busy, 32'd2, 32'd6);
    go_idle("divu_b2b");

    run_md("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 4'd0, busy, stl, mf0);
    check_res("div_neg", busy, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    go_idle("div_neg");

    run_md("divu_zero", 4'd4, 32'd100, 32'd0, 1'b1, 4'd0, busy, stl, mf0);
    check_res("divu_zero", busy, 32'd100, 32'hFFFF_FFFF);
    go_idle("divu_zero");

    run_md("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd0, busy, stl, mf0);
    check_res("div_ovf", busy, 32'd0, 32'h8000_0000);
    go_idle("div_ovf");

    run_md("mult_min", 4'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd0, busy, stl, mf0);
    check_res("mult_min", busy, 32'h4000_0000, 32'd0);
    go_idle("mult_min");

    run_md("div_zero_s", 4'd3, 32'hFFFF_FFFB, 32'd0, 1'b1, 4'd0, busy, stl, mf0);
    check_res("div_zero_s", busy, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    go_idle("div_zero_s");

    // Reserved opcode: no stall, no register change.
    op_valid = 1'b1; op = 4'd9; A = 32'hDEAD_BEEF; B = 32'd1;
    #1 chk("op9_stall", 32'(stall), 32'd0);
    @(negedge clock);
    op_valid = 1'b0; op = 4'd0;
    #1;
    chk("op9_hi", hi, 32'hFFFF_FFFB);
    chk("op9_lo", lo, 32'hFFFF_FFFF);

    // MTLO, then MULTU with an MFLO queued behind it.
    op_valid = 1'b1; op = 4'd8; A = 32'd5;
    @(negedge clock);
    op_valid = 1'b0; op = 4'd0;
    #1 chk("mtlo_lo", lo, 32'd5);
    run_md("mflo_wait", 4'd2, 32'd3, 32'd4, 1'b1, 4'd6, busy, stl, mf0);
    chk("mflo_wait_busy_mf", mf0, 32'd5);
    chk("mflo_wait_busy_stalls", 32'(stl), 32'd32);
    check_res("mflo_wait", busy, 32'd0, 32'd12);
    chk("mflo_wait_done_stall", 32'(stall), 32'd0);
    chk("mflo_wait_mf", mf_result, 32'd12);
    go_idle("mflo_wait");

    // MTHI held during BUSY, applied at the DONE edge.
    run_md("mthi_wait", 4'd2, 32'd3, 32'd4, 1'b1, 4'd7, busy, stl, mf0);
    check_res("mthi_wait", busy, 32'd0, 32'd12);
    @(negedge clock);
    op_valid = 1'b0; op = 4'd0;
    #1 chk("mthi_applied", hi, 32'h1234_5678);

    // Flush at iteration 10.
    op_valid = 1'b1; op = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clock);
    op_valid = 1'b0; op = 4'd0;
    repeat (9) @(negedge clock);
    flush = 1'b1;
    #1 chk("flush_stall", 32'(stall), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("flush_idle_stall", 32'(stall), 32'd0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'd12);
    n = 0;
    repeat (40) begin
      @(negedge clock);
      #1 if (done) n++;
    end
    chk("flush_no_done", 32'(n), 32'd0);
    chk("flush_hi_after", hi, 32'h1234_5678);

    // Reset at iteration 10.
    op_valid = 1'b1; op = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clock);
    op_valid = 1'b0; op = 4'd0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1 chk("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_stall_after", 32'(stall), 32'd0);
    n = 0;
    repeat (40) begin
      @(negedge clock);
      #1 if (done) n++;
    end
    chk("rst_mid_no_done", 32'(n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
